// File: rtl/fp_pkg.sv
// Shared FP32 field positions and the FMUL sequencing state encoding.
package fp_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      LAUNCH = 2'd1,
      WAIT   = 2'd2,
      DONE   = 2'd3
   } fmul_state_e;

   localparam int          FP32_EXP_MSB = 30;
   localparam int          FP32_EXP_LSB = 23;
   localparam int          FP32_FRAC_W  = 23;
   localparam logic [7:0]  EXP_ALL1     = 8'hFF;

endpackage

// File: rtl/fmul_issue_ctrl.sv
// Issue/writeback sequencer around the single-precision multiplier (FMUL).
// Optional FMUL_FLAGS_EN adds registered wb_nan/wb_inf/wb_zero classification outputs.
module fmul_issue_ctrl
   import fp_pkg::*;
#(
   parameter int RD_W      = 4,
   parameter int SPEC_WAIT = 2,
   parameter int TIMEOUT   = 63
) (
   input  logic            CLK,
   input  logic            RESET,
   input  logic            req_valid,
   output logic            req_ready,
   input  logic [31:0]     req_src1,
   input  logic [31:0]     req_src2,
   input  logic [RD_W-1:0] req_rd,
   output logic [31:0]     fmul_src1,
   output logic [31:0]     fmul_src2,
   output logic            fmul_start,
   input  logic [31:0]     fmul_out,
   input  logic            fmul_busy,
   output logic            wb_valid,
   input  logic            wb_ready,
   output logic [31:0]     wb_data,
   output logic [RD_W-1:0] wb_rd,
`ifdef FMUL_FLAGS_EN
   output logic            wb_nan,
   output logic            wb_inf,
   output logic            wb_zero,
`endif
   output logic            stall
);

   localparam int                CNT_W     = $clog2(TIMEOUT + 1);
   localparam logic [CNT_W-1:0]  TIMEOUT_C = CNT_W'(TIMEOUT);
   localparam logic [CNT_W-1:0]  SPEC_C    = CNT_W'(SPEC_WAIT - 1);

   fmul_state_e      state_q;
   logic [CNT_W-1:0] cnt_q;
   logic [CNT_W-1:0] cnt_d;
   logic             busy_seen_q;
   logic [31:0]      src1_q;
   logic [31:0]      src2_q;
   logic [RD_W-1:0]  rd_q;
   logic             start_q;
   logic             ready_q;
   logic             stall_q;
   logic             wb_valid_q;
   logic [31:0]      wb_data_q;
   logic [RD_W-1:0]  wb_rd_q;

   logic busy_fall;
   logic timed_out;
   logic spec_done;
   logic capture;

   assign cnt_d = (cnt_q == TIMEOUT_C) ? cnt_q : cnt_q + 1'b1;

   // All three exits capture fmul_out alike; the current busy level also
   // blocks the special-case exit so a late FBusy rise is never missed.
   assign busy_fall = busy_seen_q & ~fmul_busy;
   assign timed_out = (cnt_q == TIMEOUT_C);
   assign spec_done = ~busy_seen_q & ~fmul_busy & (cnt_q == SPEC_C);
   assign capture   = busy_fall | timed_out | spec_done;

`ifdef FMUL_FLAGS_EN
   logic       nan_q;
   logic       inf_q;
   logic       zero_q;
   logic [7:0] res_exp;
   logic       res_frac_nz;

   assign res_exp     = fmul_out[FP32_EXP_MSB:FP32_EXP_LSB];
   assign res_frac_nz = |fmul_out[FP32_FRAC_W-1:0];

   always_ff @(posedge CLK or negedge RESET) begin
      if (!RESET) begin
         nan_q  <= 1'b0;
         inf_q  <= 1'b0;
         zero_q <= 1'b0;
      end else if (state_q == WAIT && capture) begin
         nan_q  <= (res_exp == EXP_ALL1) &  res_frac_nz;
         inf_q  <= (res_exp == EXP_ALL1) & ~res_frac_nz;
         zero_q <= (res_exp == 8'h00)    & ~res_frac_nz;
      end
   end

   assign wb_nan  = nan_q;
   assign wb_inf  = inf_q;
   assign wb_zero = zero_q;
`endif

   always_ff @(posedge CLK or negedge RESET) begin
      if (!RESET) begin
         state_q     <= IDLE;
         cnt_q       <= '0;
         busy_seen_q <= 1'b0;
         src1_q      <= '0;
         src2_q      <= '0;
         rd_q        <= '0;
         start_q     <= 1'b0;
         ready_q     <= 1'b1;
         stall_q     <= 1'b0;
         wb_valid_q  <= 1'b0;
         wb_data_q   <= '0;
         wb_rd_q     <= '0;
      end else begin
         start_q <= 1'b0;
         case (state_q)
            IDLE: begin
               if (req_valid) begin
                  src1_q  <= req_src1;
                  src2_q  <= req_src2;
                  rd_q    <= req_rd;
                  start_q <= 1'b1;
                  ready_q <= 1'b0;
                  stall_q <= 1'b1;
                  state_q <= LAUNCH;
               end
            end
            LAUNCH: begin
               cnt_q       <= '0;
               busy_seen_q <= 1'b0;
               state_q     <= WAIT;
            end
            WAIT: begin
               cnt_q <= cnt_d;
               if (fmul_busy) busy_seen_q <= 1'b1;
               if (capture) begin
                  wb_data_q  <= fmul_out;
                  wb_rd_q    <= rd_q;
                  wb_valid_q <= 1'b1;
                  state_q    <= DONE;
               end
            end
            DONE: begin
               if (wb_ready) begin
                  wb_valid_q <= 1'b0;
                  ready_q    <= 1'b1;
                  stall_q    <= 1'b0;
                  state_q    <= IDLE;
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign req_ready  = ready_q;
   assign stall      = stall_q;
   assign fmul_start = start_q;
   assign fmul_src1  = src1_q;
   assign fmul_src2  = src2_q;
   assign wb_valid   = wb_valid_q;
   assign wb_data    = wb_data_q;
   assign wb_rd      = wb_rd_q;

endmodule

// File: tb/tb_fmul_issue_ctrl.sv
// Directed bench for fmul_issue_ctrl with a behavioural FMUL busy model.
module tb_fmul_issue_ctrl;

   logic        CLK = 1'b0;
   logic        RESET = 1'b0;
   logic        req_valid = 1'b0;
   logic        req_ready;
   logic [31:0] req_src1 = '0;
   logic [31:0] req_src2 = '0;
   logic [3:0]  req_rd = '0;
   logic [31:0] fmul_src1;
   logic [31:0] fmul_src2;
   logic        fmul_start;
   logic [31:0] fmul_out;
   logic        fmul_busy;
   logic        wb_valid;
   logic        wb_ready = 1'b0;
   logic [31:0] wb_data;
   logic [3:0]  wb_rd;
   logic        stall;
`ifdef FMUL_FLAGS_EN
   logic        wb_nan;
   logic        wb_inf;
   logic        wb_zero;
`endif

   fmul_issue_ctrl #(.RD_W(4), .SPEC_WAIT(2), .TIMEOUT(63)) dut (
      .CLK(CLK), .RESET(RESET),
      .req_valid(req_valid), .req_ready(req_ready),
      .req_src1(req_src1), .req_src2(req_src2), .req_rd(req_rd),
      .fmul_src1(fmul_src1), .fmul_src2(fmul_src2), .fmul_start(fmul_start),
      .fmul_out(fmul_out), .fmul_busy(fmul_busy),
      .wb_valid(wb_valid), .wb_ready(wb_ready), .wb_data(wb_data), .wb_rd(wb_rd),
`ifdef FMUL_FLAGS_EN
      .wb_nan(wb_nan), .wb_inf(wb_inf), .wb_zero(wb_zero),
`endif
      .stall(stall)
   );

   always #5 CLK = ~CLK;

   // FMUL model: busy rises the cycle after Start for cur_busy cycles;
   // cur_busy < 0 means busy never drops.
   int          cur_busy = 0;
   logic [31:0] cur_res = '0;
   int          left;
   logic        started;
   int          start_cnt = 0;
   int          src_bad = 0;
   logic [31:0] exp_a = '0;
   logic [31:0] exp_b = '0;

   assign fmul_out  = cur_res;
   assign fmul_busy = (cur_busy < 0) ? started : (left > 0);

   always @(posedge CLK or negedge RESET) begin
      if (!RESET) begin
         left    <= 0;
         started <= 1'b0;
      end else if (fmul_start) begin
         left    <= cur_busy;
         started <= (cur_busy < 0);
      end else if (left > 0) begin
         left <= left - 1;
      end
   end

   always @(posedge CLK) if (RESET && fmul_start) start_cnt <= start_cnt + 1;

   always @(negedge CLK)
      if (stall && fmul_busy && (fmul_src1 != exp_a || fmul_src2 != exp_b))
         src_bad <= src_bad + 1;

   int errors = 0;
   int checks = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
      end
   endtask

   typedef struct {
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] res;
      logic [3:0]  rd;
      int          busy;
      int          hold;
      int          lat;
      logic [2:0]  flags;   // {nan, inf, zero}
   } vec_t;

   vec_t vecs[6];

   task automatic run_vec(input int i);
      int lat;
      int s0;
      int bad;
      logic [31:0] d0;
      vec_t v;
      v = vecs[i];
      @(negedge CLK);
      check($sformatf("v%0d ready_idle", i), {31'b0, req_ready}, 32'd1);
      req_valid = 1'b1; req_src1 = v.a; req_src2 = v.b; req_rd = v.rd;
      cur_res = v.res; cur_busy = v.busy; exp_a = v.a; exp_b = v.b;
      s0 = start_cnt;
      @(posedge CLK); #1;
      req_valid = 1'b0; req_src1 = 32'hA5A5A5A5; req_src2 = 32'h5A5A5A5A; req_rd = 4'h0;
      lat = 0;
      while (1) begin
         @(negedge CLK);
         lat++;
         if (wb_valid) break;
         if (lat > 200) break;
      end
      check($sformatf("v%0d latency", i), lat, v.lat);
      check($sformatf("v%0d wb_data", i), wb_data, v.res);
      check($sformatf("v%0d wb_rd", i), {28'b0, wb_rd}, {28'b0, v.rd});
      check($sformatf("v%0d stall_done", i), {31'b0, stall}, 32'd1);
`ifdef FMUL_FLAGS_EN
      check($sformatf("v%0d flags", i), {29'b0, wb_nan, wb_inf, wb_zero}, {29'b0, v.flags});
`endif
      bad = 0;
      d0 = wb_data;
      repeat (v.hold) begin
         @(negedge CLK);
         if (!wb_valid || wb_data !== d0 || req_ready || !stall) bad++;
      end
      check($sformatf("v%0d hold_stable", i), bad, 0);
      wb_ready = 1'b1;
      @(posedge CLK); #1;
      wb_ready = 1'b0;
      @(negedge CLK);
      check($sformatf("v%0d wb_valid_drop", i), {31'b0, wb_valid}, 32'd0);
      check($sformatf("v%0d stall_idle", i), {31'b0, stall}, 32'd0);
      check($sformatf("v%0d start_once", i), start_cnt - s0, 1);
      check($sformatf("v%0d src_stable", i), src_bad, 0);
   endtask

   initial begin
      int s0;
      int lat;
      int seen;
      vecs[0] = '{32'h3FC00000, 32'h40000000, 32'h40400000, 4'h5, 48, 0, 51, 3'b000};
      vecs[1] = '{32'h00000000, 32'h40490FDB, 32'h00000000, 4'h3, 0, 0, 4, 3'b001};
      vecs[2] = '{32'h7FC00000, 32'h3F800000, 32'h7FC00000, 4'h7, 0, 0, 4, 3'b100};
      vecs[3] = '{32'h7F800000, 32'h40000000, 32'h7F800000, 4'h1, 0, 0, 4, 3'b010};
      vecs[4] = '{32'h40000000, 32'h40400000, 32'h40C00000, 4'hF, 5, 10, 8, 3'b000};
      vecs[5] = '{32'h3F800000, 32'h3F800000, 32'hDEADBEEF, 4'hA, -1, 0, 66, 3'b000};

      // Reset values
      repeat (3) @(negedge CLK);
      RESET = 1'b1;
      @(negedge CLK);
      check("rst req_ready", {31'b0, req_ready}, 32'd1);
      check("rst stall", {31'b0, stall}, 32'd0);
      check("rst wb_valid", {31'b0, wb_valid}, 32'd0);
      check("rst fmul_start", {31'b0, fmul_start}, 32'd0);
      check("rst wb_data", wb_data, 32'd0);
      check("rst wb_rd", {28'b0, wb_rd}, 32'd0);
      check("rst fmul_src1", fmul_src1, 32'd0);

      for (int i = 0; i < 6; i++) run_vec(i);

      // Back-to-back: wb_ready and a new request together in DONE costs one IDLE bubble
      @(negedge CLK);
      req_valid = 1'b1; req_src1 = 32'h3F800000; req_src2 = 32'h40000000; req_rd = 4'h2;
      cur_res = 32'h40000000; cur_busy = 0; exp_a = req_src1; exp_b = req_src2;
      s0 = start_cnt;
      @(posedge CLK); #1;
      req_valid = 1'b0;
      lat = 0;
      while (!wb_valid && lat < 200) begin @(negedge CLK); lat++; end
      check("b2b first latency", lat, 4);
      req_valid = 1'b1; wb_ready = 1'b1;
      @(posedge CLK); #1;
      wb_ready = 1'b0;
      @(negedge CLK);
      check("b2b bubble ready", {31'b0, req_ready}, 32'd1);
      check("b2b bubble stall", {31'b0, stall}, 32'd0);
      check("b2b no early start", start_cnt - s0, 1);
      @(posedge CLK); #1;
      req_valid = 1'b0;
      @(negedge CLK);
      check("b2b second start", {31'b0, fmul_start}, 32'd1);
      lat = 0;
      while (!wb_valid && lat < 200) begin @(negedge CLK); lat++; end
      check("b2b second data", wb_data, 32'h40000000);
      wb_ready = 1'b1;
      @(posedge CLK); #1;
      wb_ready = 1'b0;

      // Reset in the middle of a busy wait
      @(negedge CLK);
      req_valid = 1'b1; req_src1 = 32'h3FC00000; req_src2 = 32'h40000000; req_rd = 4'h9;
      cur_res = 32'h40400000; cur_busy = 48; exp_a = req_src1; exp_b = req_src2;
      @(posedge CLK); #1;
      req_valid = 1'b0;
      repeat (21) @(negedge CLK);
      check("midrst busy active", {31'b0, fmul_busy}, 32'd1);
      #2 RESET = 1'b0;
      #1;
      check("midrst stall", {31'b0, stall}, 32'd0);
      check("midrst wb_valid", {31'b0, wb_valid}, 32'd0);
      check("midrst fmul_src1", fmul_src1, 32'd0);
      check("midrst wb_rd", {28'b0, wb_rd}, 32'd0);
      @(negedge CLK);
      RESET = 1'b1;
      seen = 0;
      repeat (70) begin
         @(negedge CLK);
         if (wb_valid || stall) seen++;
      end
      check("midrst no wb_valid", seen, 0);
      check("midrst ready", {31'b0, req_ready}, 32'd1);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
